ckpt_scan_ctrl: RTL and testbench
=================================

CKPT_SCAN_CTRL -- requirements
Module: ckpt_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, scan word width.
REQ-002 SHALL have parameter FF_WORDS, default 4, FF-chain length in words (>=1).
REQ-003 SHALL have parameter MEM_WORDS, default 16, RAM-chain length in words (>=1).
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1) and cmd_dir (input, 1): command handshake; cmd_dir 0 = dump, 1 = restore.
REQ-007 SHALL have ports busy (output, 1) and done (output, 1): operation in progress; one-cycle completion pulse.
REQ-008 SHALL have port pause, output, 1: DUT clock-gate pause request.
REQ-009 SHALL have ports ff_scan (output, 1), ff_dir (output, 1), ff_sdi (output, DATA_WIDTH) and ff_sdo (input, DATA_WIDTH): FF chain.
REQ-010 SHALL have ports ram_scan (output, 1), ram_dir (output, 1), ram_sdi (output, DATA_WIDTH) and ram_sdo (input, DATA_WIDTH): RAM chain.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, DATA_WIDTH): dump stream.
REQ-012 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_WIDTH): restore stream.

Function
REQ-013 SHALL implement states IDLE, PAUSE, FF, RAM_WARM, RAM, RAM_FLUSH, TAIL, DONE.
REQ-014 SHALL drive cmd_ready=1 only in IDLE and accept a command on cmd_valid&&cmd_ready, latching cmd_dir; accept -> PAUSE.
REQ-015 SHALL hold pause=1 in PAUSE through TAIL and 0 in IDLE and DONE; busy=1 in every state except IDLE.
REQ-016 SHALL spend exactly one cycle in PAUSE with both scan enables low, then go to FF.
REQ-017 SHALL, in FF dump: out_valid=1, out_data=ff_sdo (combinational), ff_dir=0, ff_scan=out_ready; each out handshake counts one word.
REQ-018 SHALL, in FF restore: in_ready=1, ff_dir=1, ff_sdi=in_data, ff_scan=in_valid; each in handshake counts one word.
REQ-019 SHALL leave FF after FF_WORDS handshakes: to RAM_WARM when dumping, to RAM when restoring.
REQ-020 SHALL, in RAM_WARM: ram_scan=1, ram_dir=0, out_valid=0 for exactly 2 cycles regardless of out_ready, then go to RAM.
REQ-021 SHALL, in RAM dump: out_valid=1, out_data=ram_sdo, ram_scan=out_ready; ram_scan low freezes the RAM chain and its output pipeline.
REQ-022 SHALL, in RAM restore: in_ready=1, ram_dir=1, ram_sdi=in_data, ram_scan=in_valid.
REQ-023 SHALL leave RAM after MEM_WORDS handshakes: dump -> TAIL; restore -> RAM_FLUSH.
REQ-024 SHALL, in RAM_FLUSH: ram_scan=1, ram_dir=1 for one cycle, then go to TAIL.
REQ-025 SHALL, in TAIL: both scan enables 0, pause 1, one cycle, then go to DONE.
REQ-026 SHALL, in DONE: done=1, pause=0, cmd_ready=0 for one cycle, then go to IDLE.
REQ-027 SHALL hold ff_dir/ram_dir at the latched direction throughout FF/RAM phases; out_valid/in_ready SHALL be 0 outside the phases above; in_ready SHALL be 0 in every dump state and out_valid SHALL be 0 in every restore state.
REQ-028 SHALL use word counters of width $clog2(max(FF_WORDS,MEM_WORDS)+1) that clear on phase entry; counters never wrap.
REQ-029 SHALL ignore cmd_valid while busy; no command queueing.
REQ-030 SHALL ignore in_valid and out_ready outside the phase that consumes them.

Reset
REQ-031 SHALL, on resetn=0 at a clock edge, enter IDLE, clear counters and latched direction, and drive cmd_ready=1, busy=0, done=0, pause=0, ff_scan=0, ram_scan=0, ff_dir=0, ram_dir=0, out_valid=0, in_ready=0; data outputs are don't-care.
REQ-032 SHALL abort mid-operation on reset with no done pulse; chain contents are then undefined.

Verification (FF_WORDS=4, MEM_WORDS=16)
REQ-033 Dump, out_ready=1, cmd accepted cycle 0 -> PAUSE c1, ff_scan c2-5, warm c6-7, 16 RAM words c8-23, done c25, pause low c25.
REQ-034 Restore, in_valid=1 -> ff_scan c2-5, ram_scan c6-22 (c22 flush), done c24; subsequent DUT reads equal the dumped state.
REQ-035 Dump with out_ready toggling every other cycle -> exactly 20 handshakes, data sequence identical to the stall-free dump, no scan enable without handshake.
REQ-036 Restore with in_valid gaps of 3 cycles -> scan enables high only on valid cycles; 4 FF + 16 RAM words consumed.
REQ-037 resetn=0 in RAM phase -> next cycle all outputs at reset values, no done; fresh command then runs normally.
REQ-038 cmd_valid held high during operation -> single accept; second accept only in the cycle after DONE.

Source files
------------

// File: rtl/ckpt_scan_ctrl.sv
// Checkpoint scan controller.
// Pauses the DUT clock, then streams the flip-flop scan chain followed by the
// RAM scan chain either out to a dump stream or in from a restore stream.
// The RAM chain has a two-stage output pipeline, so a dump primes it with two
// warm-up shifts. A restore ends with one flush shift so the last word is
// committed.
module ckpt_scan_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int FF_WORDS   = 4,
  parameter int MEM_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  output logic                  busy,
  output logic                  done,
  output logic                  pause,
  output logic                  ff_scan,
  output logic                  ff_dir,
  output logic [DATA_WIDTH-1:0] ff_sdi,
  input  logic [DATA_WIDTH-1:0] ff_sdo,
  output logic                  ram_scan,
  output logic                  ram_dir,
  output logic [DATA_WIDTH-1:0] ram_sdi,
  input  logic [DATA_WIDTH-1:0] ram_sdo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data
);

  localparam int MAX_WORDS = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
  localparam int CW        = $clog2(MAX_WORDS + 1);

  localparam logic [CW-1:0] FF_LAST   = CW'(FF_WORDS - 1);
  localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_WORDS - 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PAUSE     = 3'd1,
    FF        = 3'd2,
    RAM_WARM  = 3'd3,
    RAM       = 3'd4,
    RAM_FLUSH = 3'd5,
    TAIL      = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          hs;

  // State, word counter and latched direction; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state, counter and chain/stream steering for the current phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    hs        = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    pause     = 1'b1;
    ff_scan   = 1'b0;
    ff_dir    = 1'b0;
    ff_sdi    = '0;
    ram_scan  = 1'b0;
    ram_dir   = 1'b0;
    ram_sdi   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    in_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        pause     = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          cnt_d   = '0;
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        cnt_d   = '0;
        state_d = FF;
      end

      FF: begin
        ff_dir = dir_q;
        if (!dir_q) begin
          out_valid = 1'b1;
          out_data  = ff_sdo;
          ff_scan   = out_ready;
          hs        = out_ready;
        end else begin
          in_ready = 1'b1;
          ff_sdi   = in_data;
          ff_scan  = in_valid;
          hs       = in_valid;
        end
        if (hs) begin
          if (cnt_q == FF_LAST) begin
            cnt_d   = '0;
            state_d = dir_q ? RAM : RAM_WARM;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      RAM_WARM: begin
        ram_scan = 1'b1;
        ram_dir  = 1'b0;
        if (cnt_q == WARM_LAST) begin
          cnt_d   = '0;
          state_d = RAM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RAM: begin
        ram_dir = dir_q;
        if (!dir_q) begin
          out_valid = 1'b1;
          out_data  = ram_sdo;
          ram_scan  = out_ready;
          hs        = out_ready;
        end else begin
          in_ready = 1'b1;
          ram_sdi  = in_data;
          ram_scan = in_valid;
          hs       = in_valid;
        end
        if (hs) begin
          if (cnt_q == MEM_LAST) begin
            cnt_d   = '0;
            state_d = dir_q ? RAM_FLUSH : TAIL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      RAM_FLUSH: begin
        ram_scan = 1'b1;
        ram_dir  = 1'b1;
        state_d  = TAIL;
      end

      TAIL: begin
        state_d = DONE;
      end

      DONE: begin
        pause   = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ckpt_scan_ctrl.sv
// Randomized scoreboard bench for ckpt_scan_ctrl.
// The bench emulates the scan chains and keeps a golden copy of the DUT state.
// A dump expects the golden words in chain order. A restore replaces the
// golden state with the words sent.
`timescale 1ns/1ps
module tb_ckpt_scan_ctrl;

  localparam int DW  = 64;
  localparam int FFW = 4;
  localparam int MW  = 16;
  localparam int NW  = FFW + MW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic          busy, done, pause;
  logic          ff_scan, ff_dir, ram_scan, ram_dir;
  logic [DW-1:0] ff_sdi, ff_sdo, ram_sdi, ram_sdo;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;

  ckpt_scan_ctrl #(.DATA_WIDTH(DW), .FF_WORDS(FFW), .MEM_WORDS(MW)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .busy(busy), .done(done), .pause(pause),
    .ff_scan(ff_scan), .ff_dir(ff_dir), .ff_sdi(ff_sdi), .ff_sdo(ff_sdo),
    .ram_scan(ram_scan), .ram_dir(ram_dir), .ram_sdi(ram_sdi), .ram_sdo(ram_sdo),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] gold_ff[FFW];
  logic [DW-1:0] gold_mem[MW];
  logic          cur_dir = 1'b0;
  logic          env_load = 1'b0;

  // Cycle counter used to time phases relative to command acceptance.
  always @(posedge clk) cyc <= cyc + 1;

  // Chain emulation: circular FF chain, RAM with a two-stage read pipeline
  // and a one-word write staging register.
  logic [DW-1:0] ff_chain[FFW];
  logic [DW-1:0] mem[MW];
  logic [DW-1:0] ram_a, ram_b, pend;
  logic          pend_v;
  int            rd_ptr, wr_ptr;

  assign ff_sdo  = ff_chain[0];
  assign ram_sdo = ram_b;

  always @(posedge clk) begin
    if (env_load) begin
      for (int i = 0; i < FFW; i++) ff_chain[i] <= gold_ff[i];
      for (int i = 0; i < MW; i++) mem[i] <= gold_mem[i];
      ram_a <= '0;
      ram_b <= '0;
      pend  <= '0;
    end else if (ff_scan) begin
      for (int i = 0; i < FFW - 1; i++) ff_chain[i] <= ff_chain[i+1];
      ff_chain[FFW-1] <= ff_dir ? ff_sdi : ff_chain[0];
    end
    if (!busy) begin
      rd_ptr <= 0;
      wr_ptr <= 0;
      pend_v <= 1'b0;
    end else if (ram_scan) begin
      if (!ram_dir) begin
        ram_b  <= ram_a;
        ram_a  <= mem[rd_ptr % MW];
        rd_ptr <= rd_ptr + 1;
      end else begin
        if (pend_v) begin
          mem[wr_ptr % MW] <= pend;
          wr_ptr <= wr_ptr + 1;
        end
        pend   <= ram_sdi;
        pend_v <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    checkOutput("rst_busy",      64'(busy),      64'(0));
    checkOutput("rst_done",      64'(done),      64'(0));
    checkOutput("rst_pause",     64'(pause),     64'(0));
    checkOutput("rst_ff_scan",   64'(ff_scan),   64'(0));
    checkOutput("rst_ram_scan",  64'(ram_scan),  64'(0));
    checkOutput("rst_ff_dir",    64'(ff_dir),    64'(0));
    checkOutput("rst_ram_dir",   64'(ram_dir),   64'(0));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_in_ready",  64'(in_ready),  64'(0));
  endtask

  // Monitor: pops the scoreboard on every dump handshake and checks the
  // per-cycle protocol rules.
  always @(negedge clk) begin
    logic hs_any;
    logic [DW-1:0] exp_word;
    if (resetn && !env_load) begin
      hs_any = (out_valid && out_ready) || (in_valid && in_ready);
      checkOutput("cmd_ready_eq_idle", 64'(cmd_ready), 64'(!busy));
      checkOutput("pause_window", 64'(pause), 64'(busy && !done));
      checkOutput("out_valid_in_restore", 64'(out_valid && cur_dir), 64'(0));
      checkOutput("in_ready_in_dump", 64'(in_ready && !cur_dir), 64'(0));
      if (!busy)
        checkOutput("idle_quiet", 64'({out_valid, in_ready, ff_scan, ram_scan}), 64'(0));
      if (ff_scan) begin
        checkOutput("ff_scan_needs_hs", 64'(hs_any), 64'(1));
        checkOutput("ff_dir", 64'(ff_dir), 64'(cur_dir));
      end
      if (ram_scan)
        checkOutput("ram_dir", 64'(ram_dir), 64'(cur_dir));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 64'(sb.size()), 64'(1));
        end else begin
          exp_word = sb.pop_front();
          checkOutput("dump_word", out_data, exp_word);
        end
      end
    end
  end

  // Runs one command (two when hold is set) with the given stream pattern:
  // mode 0 = always ready/valid, 1 = toggled/gapped, 2 = random.
  // abort_at > 0 asserts reset that many cycles after acceptance.
  task automatic applyStimulus(input logic dir, input int mode, input bit hold, input int abort_at);
    int accepts = 0, dones = 0, hs = 0, idx = 0, budget = 0;
    int acc_cyc[2], done_cyc[2];
    int last_hs = 0, first_ff = -1, ram_sc = 0, ram_nohs = 0;
    int n_ops = hold ? 2 : 1;
    bit aborted = 0, do_abort = 0, hs_now;
    logic [DW-1:0] words[NW];
    acc_cyc = '{0, 0};
    done_cyc = '{0, 0};
    for (int i = 0; i < NW; i++) words[i] = {$urandom, $urandom};

    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    out_ready = (mode == 0) ? 1'b1 : 1'b0;
    in_valid  = dir && (mode != 2 || $urandom_range(0, 1) == 1);
    in_data   = words[0];

    while (dones < n_ops && budget < 2000 && !aborted) begin
      @(negedge clk);
      hs_now = (out_valid && out_ready) || (in_valid && in_ready);
      if (cmd_valid && cmd_ready) begin
        cur_dir = dir;
        acc_cyc[accepts] = cyc;
        accepts++;
        if (!dir) begin
          for (int i = 0; i < FFW; i++) sb.push_back(gold_ff[i]);
          for (int i = 0; i < MW; i++) sb.push_back(gold_mem[i]);
        end
      end
      if (hs_now) begin hs++; last_hs = cyc; end
      if (in_valid && in_ready) idx++;
      if (ff_scan && first_ff < 0) first_ff = cyc;
      if (ram_scan) ram_sc++;
      if (ram_scan && !hs_now) ram_nohs++;
      if (done) begin done_cyc[dones] = cyc; dones++; end
      if (abort_at > 0 && accepts > 0 && cyc == acc_cyc[0] + abort_at) do_abort = 1;

      @(posedge clk); #1;
      budget++;
      if (do_abort) begin
        resetn = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetValues();
        checkOutput("abort_no_done", 64'(dones), 64'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        sb.delete();
        aborted = 1;
      end else begin
        cmd_valid = (accepts < n_ops);
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = cyc[0];
          default: out_ready = $urandom_range(0, 1) == 1;
        endcase
        in_valid = dir && idx < NW &&
                   (mode == 0 || (mode == 1 && budget % 4 == 0) ||
                    (mode == 2 && $urandom_range(0, 1) == 1));
        in_data = words[(idx < NW) ? idx : 0];
      end
    end

    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    if (!aborted) begin
      checkOutput("op_complete", 64'(dones), 64'(n_ops));
      checkOutput("handshakes", 64'(hs), 64'(NW * n_ops));
      checkOutput("ram_scan_cycles", 64'(ram_sc), 64'(n_ops * (dir ? MW + 1 : MW + 2)));
      checkOutput("ram_scan_no_hs", 64'(ram_nohs), 64'(n_ops * (dir ? 1 : 2)));
      checkOutput("done_after_last_hs", 64'(done_cyc[n_ops-1] - last_hs), 64'(dir ? 3 : 2));
      checkOutput("sb_drained", 64'(sb.size()), 64'(0));
      if (mode == 0) begin
        checkOutput("done_latency", 64'(done_cyc[0] - acc_cyc[0]), 64'(dir ? 24 : 25));
        checkOutput("first_ff_scan", 64'(first_ff - acc_cyc[0]), 64'(2));
      end
      if (hold) begin
        checkOutput("accept_count", 64'(accepts), 64'(2));
        checkOutput("second_accept", 64'(acc_cyc[1]), 64'(done_cyc[0] + 1));
      end
      if (dir && idx == NW) begin
        for (int i = 0; i < FFW; i++) gold_ff[i] = words[i];
        for (int i = 0; i < MW; i++) gold_mem[i] = words[FFW + i];
      end
    end
    // Idle cycles with stray stream activity that must be ignored.
    repeat (3) begin
      @(posedge clk); #1;
      out_ready = $urandom_range(0, 1) == 1;
      in_valid  = $urandom_range(0, 1) == 1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < FFW; i++) gold_ff[i] = {$urandom, $urandom};
    for (int i = 0; i < MW; i++) gold_mem[i] = {$urandom, $urandom};
    env_load = 1'b1;
    repeat (3) @(posedge clk);
    #1 env_load = 1'b0;
    @(negedge clk);
    checkResetValues();
    @(posedge clk); #1;
    resetn = 1'b1;

    applyStimulus(1'b0, 0, 1'b0, 0);
    applyStimulus(1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 0, 1'b0, 0);
    applyStimulus(1'b0, 1, 1'b0, 0);
    applyStimulus(1'b1, 1, 1'b0, 0);
    applyStimulus(1'b0, 2, 1'b0, 0);
    applyStimulus(1'b0, 0, 1'b0, 12);
    applyStimulus(1'b0, 0, 1'b0, 0);
    applyStimulus(1'b0, 0, 1'b1, 0);
    applyStimulus(1'b1, 2, 1'b0, 0);
    applyStimulus(1'b0, 2, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
